// File: rtl/board_keeper_if.sv
// Move interface between the game controller (master) and the board keeper (slave).
interface board_keeper_if;
    logic        clear;
    logic [3:0]  addr;
    logic [1:0]  cellState;
    logic [17:0] gBoard;
    logic        gameIsDone;
    logic [1:0]  winner;
    logic [3:0]  moveCount;
    logic        writeAck;
    logic        writeNak;

    modport master (
        output clear, addr, cellState,
        input  gBoard, gameIsDone, winner, moveCount, writeAck, writeNak
    );

    modport slave (
        input  clear, addr, cellState,
        output gBoard, gameIsDone, winner, moveCount, writeAck, writeNak
    );
endinterface

// File: rtl/board_keeper.sv
// Holds the 3x3 board, validates single-cycle cell writes, and judges win/tie
// in a one-cycle EVAL state after every accepted move.
module board_keeper #(
    parameter int         N_CELLS  = 9,
    parameter logic [3:0] NOP_ADDR = 4'hF
) (
    input logic            ph1,
    input logic            reset,
    board_keeper_if.slave  bus
);
    typedef enum logic [1:0] {PLAY, EVAL, DONE} state_t;

    state_t                   state;
    logic [2*N_CELLS-1:0]     board;
    logic [3:0]               move_cnt;
    logic [1:0]               last_mover;
    logic [1:0]               win_q;
    logic                     done_q;
    logic                     ack_q;
    logic                     nak_q;

    logic                     wr_req;
    logic [1:0]               tgt;
    logic                     accept;

    function automatic logic has_line(input logic [2*N_CELLS-1:0] b, input logic [1:0] p);
        logic [N_CELLS-1:0] m;
        for (int i = 0; i < N_CELLS; i++) m[i] = (b[2*i +: 2] == p);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    // Out-of-range addresses read as occupied so they fall into the reject path.
    always_comb begin
        tgt = 2'b11;
        for (int i = 0; i < N_CELLS; i++)
            if (bus.addr == 4'(i)) tgt = board[2*i +: 2];
    end

    assign wr_req = (bus.addr != NOP_ADDR);
    assign accept = wr_req && (state == PLAY) && bus.cellState[1] && (tgt == 2'b00);

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state      <= PLAY;
            board      <= '0;
            move_cnt   <= '0;
            last_mover <= '0;
            win_q      <= '0;
            done_q     <= 1'b0;
            ack_q      <= 1'b0;
            nak_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            nak_q <= 1'b0;
            if (bus.clear) begin
                state    <= PLAY;
                board    <= '0;
                move_cnt <= '0;
                win_q    <= '0;
                done_q   <= 1'b0;
            end else begin
                if (accept) begin
                    for (int i = 0; i < N_CELLS; i++)
                        if (bus.addr == 4'(i)) board[2*i +: 2] <= bus.cellState;
                    move_cnt   <= move_cnt + 4'd1;
                    last_mover <= bus.cellState;
                    ack_q      <= 1'b1;
                    state      <= EVAL;
                end else if (wr_req) begin
                    nak_q <= 1'b1;
                end

                // EVAL never accepts a write, so it cannot collide with the branch above.
                if (state == EVAL) begin
                    if (has_line(board, last_mover)) begin
                        win_q  <= last_mover;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (move_cnt == 4'(N_CELLS)) begin
                        win_q  <= 2'b01;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= PLAY;
                    end
                end
            end
        end
    end

    assign bus.gBoard     = board;
    assign bus.moveCount  = move_cnt;
    assign bus.winner     = win_q;
    assign bus.gameIsDone = done_q;
    assign bus.writeAck   = ack_q;
    assign bus.writeNak   = nak_q;
endmodule

// File: tb/tb_board_keeper.sv
// Directed bench: stimulus pushes expected Ack/Nak responses, a monitor pops and checks them.
module tb_board_keeper;
    logic ph1 = 1'b0;
    logic reset = 1'b0;
    board_keeper_if bif();

    board_keeper dut (.ph1(ph1), .reset(reset), .bus(bif.slave));

    always #5 ph1 = ~ph1;

    typedef struct {
        bit          ack;
        logic [17:0] board;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] mbd;
    logic [3:0]  mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor, sampling on the falling edge.
    always @(negedge ph1) begin
        if (reset && (bif.writeAck || bif.writeNak)) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: ack=%0b nak=%0b with no pending write", bif.writeAck, bif.writeNak);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_ack", {31'd0, bif.writeAck}, {31'd0, e.ack});
                chk("resp_nak", {31'd0, bif.writeNak}, {31'd0, !e.ack});
                chk("resp_board", {14'd0, bif.gBoard}, {14'd0, e.board});
                chk("resp_cnt", {28'd0, bif.moveCount}, {28'd0, e.cnt});
            end
        end
    end

    // Called on a falling edge; presents the write for one cycle.
    task automatic wr(input logic [3:0] a, input logic [1:0] s, input bit exp_ack, input int idle);
        exp_t e;
        bif.addr = a;
        bif.cellState = s;
        if (exp_ack) begin
            mbd[2*a +: 2] = s;
            mcnt++;
        end
        e.ack = exp_ack; e.board = mbd; e.cnt = mcnt;
        sbq.push_back(e);
        @(negedge ph1);
        bif.addr = 4'hF;
        bif.cellState = 2'b00;
        repeat (idle) @(negedge ph1);
    endtask

    task automatic do_clear(input bit with_write);
        bif.clear = 1'b1;
        if (with_write) begin
            bif.addr = 4'd4;
            bif.cellState = 2'b11;
        end
        @(negedge ph1);
        bif.clear = 1'b0;
        bif.addr = 4'hF;
        bif.cellState = 2'b00;
        mbd = '0; mcnt = '0;
        @(negedge ph1);
        chk("clear_board", {14'd0, bif.gBoard}, 32'd0);
        chk("clear_cnt", {28'd0, bif.moveCount}, 32'd0);
        chk("clear_winner", {30'd0, bif.winner}, 32'd0);
        chk("clear_done", {31'd0, bif.gameIsDone}, 32'd0);
    endtask

    task automatic chk_result(input string name, input logic [1:0] w, input logic [3:0] c);
        chk({name, "_winner"}, {30'd0, bif.winner}, {30'd0, w});
        chk({name, "_done"}, {31'd0, bif.gameIsDone}, 32'd1);
        chk({name, "_cnt"}, {28'd0, bif.moveCount}, {28'd0, c});
    endtask

    initial begin
        bif.clear = 1'b0;
        bif.addr = 4'hF;
        bif.cellState = 2'b00;
        mbd = '0; mcnt = '0;
        repeat (3) @(negedge ph1);
        reset = 1'b1;
        repeat (5) @(negedge ph1);
        chk("rst_board", {14'd0, bif.gBoard}, 32'd0);
        chk("rst_cnt", {28'd0, bif.moveCount}, 32'd0);
        chk("rst_winner", {30'd0, bif.winner}, 32'd0);
        chk("rst_done", {31'd0, bif.gameIsDone}, 32'd0);

        // Row-0 win for O
        wr(4'd0, 2'b11, 1, 2);
        wr(4'd3, 2'b10, 1, 2);
        wr(4'd1, 2'b11, 1, 2);
        wr(4'd4, 2'b10, 1, 2);
        wr(4'd2, 2'b11, 1, 0);
        chk("row_bits", {26'd0, bif.gBoard[5:0]}, 32'h3F);
        chk("row_done_early", {31'd0, bif.gameIsDone}, 32'd0);
        @(negedge ph1);
        chk_result("row", 2'b11, 4'd5);
        wr(4'd8, 2'b10, 0, 1);
        chk("done_hold_board", {14'd0, bif.gBoard}, {14'd0, mbd});
        chk("done_hold_winner", {30'd0, bif.winner}, 32'd3);
        do_clear(0);

        // Rejections
        wr(4'd0, 2'b11, 1, 2);
        wr(4'd0, 2'b10, 0, 1);
        wr(4'd9, 2'b11, 0, 1);
        wr(4'd5, 2'b01, 0, 1);
        wr(4'd1, 2'b10, 1, 0);
        wr(4'd2, 2'b11, 0, 2);
        chk("rej_board", {14'd0, bif.gBoard}, {14'd0, 18'h0000B});
        chk("rej_cnt", {28'd0, bif.moveCount}, 32'd2);
        chk("rej_done", {31'd0, bif.gameIsDone}, 32'd0);
        do_clear(0);

        // Full-board tie
        wr(4'd0, 2'b11, 1, 2); wr(4'd1, 2'b10, 1, 2); wr(4'd2, 2'b11, 1, 2);
        wr(4'd4, 2'b10, 1, 2); wr(4'd3, 2'b11, 1, 2); wr(4'd5, 2'b10, 1, 2);
        wr(4'd7, 2'b11, 1, 2); wr(4'd6, 2'b10, 1, 2);
        chk("tie_pre_done", {31'd0, bif.gameIsDone}, 32'd0);
        wr(4'd8, 2'b11, 1, 1);
        chk_result("tie", 2'b01, 4'd9);
        do_clear(0);

        // Ninth-move win beats tie
        wr(4'd0, 2'b10, 1, 2); wr(4'd1, 2'b11, 1, 2); wr(4'd2, 2'b10, 1, 2);
        wr(4'd4, 2'b11, 1, 2); wr(4'd3, 2'b10, 1, 2); wr(4'd5, 2'b11, 1, 2);
        wr(4'd7, 2'b10, 1, 2); wr(4'd8, 2'b11, 1, 2);
        wr(4'd6, 2'b10, 1, 1);
        chk_result("win9", 2'b10, 4'd9);
        do_clear(0);

        // clear together with a write: the write is dropped silently
        do_clear(1);
        wr(4'd4, 2'b11, 1, 2);
        chk("post_clear_board", {14'd0, bif.gBoard}, {14'd0, 18'h00300});

        // Asynchronous reset while in EVAL with an Ack pending
        bif.addr = 4'd2;
        bif.cellState = 2'b10;
        @(posedge ph1);
        #1;
        bif.addr = 4'hF;
        bif.cellState = 2'b00;
        chk("pre_rst_board", {14'd0, bif.gBoard}, {14'd0, 18'h00320});
        reset = 1'b0;
        #1;
        chk("arst_board", {14'd0, bif.gBoard}, 32'd0);
        chk("arst_cnt", {28'd0, bif.moveCount}, 32'd0);
        chk("arst_ack", {31'd0, bif.writeAck}, 32'd0);
        chk("arst_nak", {31'd0, bif.writeNak}, 32'd0);
        chk("arst_winner", {30'd0, bif.winner}, 32'd0);
        chk("arst_done", {31'd0, bif.gameIsDone}, 32'd0);
        @(negedge ph1);
        reset = 1'b1;
        repeat (3) @(negedge ph1);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
